// File: rtl/oled_spi_sink_pkg.sv
// Shared opcodes, addressing modes and reset defaults for the OLED
// SPI driver and its receive-side sink.
package oled_spi_sink_pkg;

  localparam logic [7:0] OP_DISP_OFF   = 8'hAE;
  localparam logic [7:0] OP_DISP_ON    = 8'hAF;
  localparam logic [7:0] OP_ENTIRE_OFF = 8'hA4;
  localparam logic [7:0] OP_ENTIRE_ON  = 8'hA5;
  localparam logic [7:0] OP_NORMAL     = 8'hA6;
  localparam logic [7:0] OP_INVERSE    = 8'hA7;
  localparam logic [7:0] OP_CONTRAST   = 8'h81;
  localparam logic [7:0] OP_ADDR_MODE  = 8'h20;
  localparam logic [7:0] OP_PAGE_BASE  = 8'hB0;

  localparam logic [1:0] MODE_HORZ = 2'd0;
  localparam logic [1:0] MODE_VERT = 2'd1;
  localparam logic [1:0] MODE_PAGE = 2'd2;

  localparam logic [7:0] CONTRAST_RST = 8'h7F;
  localparam logic [1:0] MODE_RST     = MODE_PAGE;

  typedef enum logic [1:0] {
    ST_OPCODE,
    ST_ARG_CONTRAST,
    ST_ARG_MODE
  } cmd_state_e;

  // Column opcodes 00h-0Fh / 10h-1Fh load one nibble each.
  function automatic logic [7:0] set_nibble(
    input logic [7:0] v,
    input logic       hi,
    input logic [3:0] n
  );
    return hi ? {n, v[3:0]} : {v[7:4], n};
  endfunction

endpackage

// File: rtl/oled_spi_deserializer.sv
// Pin synchronisers, sclk edge detect and MSB-first byte shifter
// for the OLED SPI sink.
module oled_spi_deserializer #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_sclk,
  input  logic       i_sdin,
  input  logic       i_cmd,
  input  logic       i_cs,
  input  logic       i_res,
  output logic       o_byte_stb,
  output logic [7:0] o_byte,
  output logic       o_byte_is_data,
  output logic       o_res_n
);

  // Bit order {res, cs, cmd, sdin, sclk}; idle levels at reset.
  localparam logic [4:0] SYNC_RST = 5'b11000;

  logic [SYNC_STAGES-1:0][4:0] r_sync;
  logic [4:0] w_pins;
  logic [4:0] w_s;
  logic       w_sclk;
  logic       w_sdin;
  logic       w_cmd;
  logic       w_cs;
  logic       w_res;
  logic       r_sclk_d;
  logic       r_cs_d;
  logic [6:0] r_shift;
  logic [2:0] r_cnt;
  logic       w_take;

  assign w_pins = {i_res, i_cs, i_cmd, i_sdin, i_sclk};
  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_sclk = w_s[0];
  assign w_sdin = w_s[1];
  assign w_cmd  = w_s[2];
  assign w_cs   = w_s[3];
  assign w_res  = w_s[4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{SYNC_RST}};
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], w_pins};
    end
  end

  // cs is judged one sample back so a final edge coinciding with
  // cs rising still completes its byte.
  assign w_take = w_sclk & ~r_sclk_d & ~r_cs_d & w_res;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_d <= 1'b0;
      r_cs_d   <= 1'b1;
      r_shift  <= '0;
      r_cnt    <= '0;
    end else begin
      r_sclk_d <= w_sclk;
      r_cs_d   <= w_cs;
      if (!w_res) begin
        r_shift <= '0;
        r_cnt   <= '0;
      end else begin
        if (w_take) begin
          r_shift <= {r_shift[5:0], w_sdin};
          r_cnt   <= r_cnt + 3'd1;
        end
        if (w_cs) r_cnt <= '0;
      end
    end
  end

  assign o_byte_stb     = w_take & (r_cnt == 3'd7);
  assign o_byte         = {r_shift, w_sdin};
  assign o_byte_is_data = w_cmd;
  assign o_res_n        = w_res;

endmodule

// File: rtl/oled_spi_sink.sv
// SSD1306-style SPI receiver: command decode, configuration
// registers and GDDRAM write strobes with address auto-advance.
module oled_spi_sink
  import oled_spi_sink_pkg::*;
#(
  parameter int DISPLAY_WIDTH = 128,
  parameter int DISPLAY_PAGES = 8,
  parameter int SYNC_STAGES   = 2,
  localparam int CW = $clog2(DISPLAY_WIDTH),
  localparam int PW = $clog2(DISPLAY_PAGES),
  localparam int AW = $clog2(DISPLAY_WIDTH*DISPLAY_PAGES)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          sclk,
  input  logic          sdin,
  input  logic          res,
  input  logic          cmd,
  input  logic          cs,
  output logic          display_on,
  output logic [7:0]    contrast,
  output logic          inverse,
  output logic          entire_on,
  output logic [1:0]    addr_mode,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [7:0]    wr_data,
  output logic          byte_valid,
  output logic [7:0]    byte_data,
  output logic          byte_is_data,
  output logic          cmd_unknown
);

  logic       w_stb;
  logic [7:0] w_byte;
  logic       w_is_data;
  logic       w_res_n;

  oled_spi_deserializer #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_deser (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_sclk        (sclk),
    .i_sdin        (sdin),
    .i_cmd         (cmd),
    .i_cs          (cs),
    .i_res         (res),
    .o_byte_stb    (w_stb),
    .o_byte        (w_byte),
    .o_byte_is_data(w_is_data),
    .o_res_n       (w_res_n)
  );

  cmd_state_e    r_state, w_state;
  logic          r_disp, w_disp;
  logic [7:0]    r_con, w_con;
  logic          r_inv, w_inv;
  logic          r_ent, w_ent;
  logic [1:0]    r_mode, w_mode;
  logic [CW-1:0] r_col, w_col;
  logic [PW-1:0] r_page, w_page;
  logic          r_wr_en, w_wr_en;
  logic [AW-1:0] r_wr_addr, w_wr_addr;
  logic [7:0]    r_wr_data, w_wr_data;
  logic          r_bv, w_bv;
  logic [7:0]    r_bd, w_bd;
  logic          r_bid, w_bid;
  logic          r_unk, w_unk;

  logic          w_col_last;
  logic          w_page_last;
  logic [CW-1:0] w_col_inc;
  logic [PW-1:0] w_page_inc;
  logic          w_op_disp;
  logic          w_op_ent;
  logic          w_op_inv;
  logic          w_op_con;
  logic          w_op_mode;
  logic          w_op_col;
  logic          w_op_page;

  assign w_col_last  = (r_col == CW'(DISPLAY_WIDTH-1));
  assign w_page_last = (r_page == PW'(DISPLAY_PAGES-1));
  assign w_col_inc   = w_col_last ? '0 : r_col + CW'(1);
  assign w_page_inc  = w_page_last ? '0 : r_page + PW'(1);

  assign w_op_disp = (w_byte[7:1] == OP_DISP_OFF[7:1]);
  assign w_op_ent  = (w_byte[7:1] == OP_ENTIRE_OFF[7:1]);
  assign w_op_inv  = (w_byte[7:1] == OP_NORMAL[7:1]);
  assign w_op_con  = (w_byte == OP_CONTRAST);
  assign w_op_mode = (w_byte == OP_ADDR_MODE);
  assign w_op_col  = (w_byte[7:5] == 3'b000);
  assign w_op_page = (w_byte[7:4] == OP_PAGE_BASE[7:4]) &&
                     (int'(w_byte[3:0]) < DISPLAY_PAGES);

  always_comb begin
    w_state   = r_state;
    w_disp    = r_disp;
    w_con     = r_con;
    w_inv     = r_inv;
    w_ent     = r_ent;
    w_mode    = r_mode;
    w_col     = r_col;
    w_page    = r_page;
    w_wr_en   = 1'b0;
    w_wr_addr = r_wr_addr;
    w_wr_data = r_wr_data;
    w_bv      = 1'b0;
    w_bd      = r_bd;
    w_bid     = r_bid;
    w_unk     = 1'b0;
    if (w_stb) begin
      w_bv  = 1'b1;
      w_bd  = w_byte;
      w_bid = w_is_data;
      if (w_is_data) begin
        w_wr_en   = 1'b1;
        w_wr_addr = AW'({r_page, r_col});
        w_wr_data = w_byte;
        unique case (r_mode)
          MODE_HORZ: begin
            w_col = w_col_inc;
            if (w_col_last) w_page = w_page_inc;
          end
          MODE_VERT: begin
            w_page = w_page_inc;
            if (w_page_last) w_col = w_col_inc;
          end
          default: w_col = w_col_inc;
        endcase
      end else begin
        unique case (r_state)
          ST_ARG_CONTRAST: begin
            w_con   = w_byte;
            w_state = ST_OPCODE;
          end
          ST_ARG_MODE: begin
            if (w_byte <= {6'd0, MODE_PAGE}) w_mode = w_byte[1:0];
            w_state = ST_OPCODE;
          end
          default: begin
            unique case (1'b1)
              w_op_disp: w_disp  = w_byte[0];
              w_op_ent:  w_ent   = w_byte[0];
              w_op_inv:  w_inv   = w_byte[0];
              w_op_con:  w_state = ST_ARG_CONTRAST;
              w_op_mode: w_state = ST_ARG_MODE;
              w_op_col:  w_col   = CW'(set_nibble(8'(r_col),
                                                 w_byte[4],
                                                 w_byte[3:0]));
              w_op_page: w_page  = PW'(w_byte[3:0]);
              default:   w_unk   = 1'b1;
            endcase
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_OPCODE;
      r_disp    <= 1'b0;
      r_con     <= CONTRAST_RST;
      r_inv     <= 1'b0;
      r_ent     <= 1'b0;
      r_mode    <= MODE_RST;
      r_col     <= '0;
      r_page    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_bv      <= 1'b0;
      r_bd      <= '0;
      r_bid     <= 1'b0;
      r_unk     <= 1'b0;
    end else if (!w_res_n) begin
      // Display res pin: soft reset overrides any completing byte.
      r_state   <= ST_OPCODE;
      r_disp    <= 1'b0;
      r_con     <= CONTRAST_RST;
      r_inv     <= 1'b0;
      r_ent     <= 1'b0;
      r_mode    <= MODE_RST;
      r_col     <= '0;
      r_page    <= '0;
      r_wr_en   <= 1'b0;
      r_wr_addr <= '0;
      r_wr_data <= '0;
      r_bv      <= 1'b0;
      r_bd      <= '0;
      r_bid     <= 1'b0;
      r_unk     <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_disp    <= w_disp;
      r_con     <= w_con;
      r_inv     <= w_inv;
      r_ent     <= w_ent;
      r_mode    <= w_mode;
      r_col     <= w_col;
      r_page    <= w_page;
      r_wr_en   <= w_wr_en;
      r_wr_addr <= w_wr_addr;
      r_wr_data <= w_wr_data;
      r_bv      <= w_bv;
      r_bd      <= w_bd;
      r_bid     <= w_bid;
      r_unk     <= w_unk;
    end
  end

  assign display_on   = r_disp;
  assign contrast     = r_con;
  assign inverse      = r_inv;
  assign entire_on    = r_ent;
  assign addr_mode    = r_mode;
  assign wr_en        = r_wr_en;
  assign wr_addr      = r_wr_addr;
  assign wr_data      = r_wr_data;
  assign byte_valid   = r_bv;
  assign byte_data    = r_bd;
  assign byte_is_data = r_bid;
  assign cmd_unknown  = r_unk;

endmodule

// File: tb/tb_oled_spi_sink.sv
// Self-checking bench for oled_spi_sink: table vectors, directed
// corner sequences and random traffic against a linear-address model.
module tb_oled_spi_sink;

  localparam int W  = 128;
  localparam int P  = 8;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sclk = 1'b0;
  logic          sdin = 1'b0;
  logic          res = 1'b1;
  logic          cmd = 1'b0;
  logic          cs = 1'b1;
  logic          display_on;
  logic [7:0]    contrast;
  logic          inverse;
  logic          entire_on;
  logic [1:0]    addr_mode;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;
  logic          byte_valid;
  logic [7:0]    byte_data;
  logic          byte_is_data;
  logic          cmd_unknown;

  always #5 clk = ~clk;

  oled_spi_sink #(
    .DISPLAY_WIDTH(W),
    .DISPLAY_PAGES(P),
    .SYNC_STAGES(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .sdin(sdin),
    .res(res), .cmd(cmd), .cs(cs),
    .display_on(display_on), .contrast(contrast),
    .inverse(inverse), .entire_on(entire_on),
    .addr_mode(addr_mode), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .byte_valid(byte_valid),
    .byte_data(byte_data), .byte_is_data(byte_is_data),
    .cmd_unknown(cmd_unknown)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [17:0] q_wr[$];
  logic [17:0] e_wr[$];
  logic [8:0]  q_bv[$];
  logic [8:0]  e_bv[$];
  int unk_seen = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) q_wr.push_back({wr_addr, wr_data});
      if (byte_valid) q_bv.push_back({byte_is_data, byte_data});
      if (cmd_unknown) unk_seen++;
    end
  end

  // Reference model: pointer kept as a linear index per mode.
  int m_disp, m_con, m_inv, m_ent, m_mode;
  int m_col, m_page, m_st, m_unk;

  function automatic void m_reset();
    m_disp = 0; m_con = 'h7F; m_inv = 0; m_ent = 0; m_mode = 2;
    m_col = 0; m_page = 0; m_st = 0;
  endfunction

  function automatic void m_apply(input int b, input bit d);
    int a;
    e_bv.push_back({d, 8'(b)});
    if (d) begin
      e_wr.push_back({10'(m_page * W + m_col), 8'(b)});
      if (m_mode == 0) begin
        a = (m_page * W + m_col + 1) % (W * P);
        m_page = a / W; m_col = a % W;
      end else if (m_mode == 1) begin
        a = (m_col * P + m_page + 1) % (W * P);
        m_col = a / P; m_page = a % P;
      end else begin
        m_col = (m_col + 1) % W;
      end
    end else if (m_st == 1) begin
      m_con = b; m_st = 0;
    end else if (m_st == 2) begin
      if (b <= 2) m_mode = b;
      m_st = 0;
    end else begin
      if (b == 'hAE || b == 'hAF) m_disp = b & 1;
      else if (b == 'hA4 || b == 'hA5) m_ent = b & 1;
      else if (b == 'hA6 || b == 'hA7) m_inv = b & 1;
      else if (b == 'h81) m_st = 1;
      else if (b == 'h20) m_st = 2;
      else if (b < 16) m_col = (m_col & 'hF0) | b;
      else if (b < 32) m_col = (((b & 15) << 4) | (m_col & 15)) % W;
      else if (b >= 'hB0 && b < 'hB0 + P) m_page = b - 'hB0;
      else m_unk++;
    end
  endfunction

  function automatic void check(input string n,
                                input logic [31:0] act,
                                input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endfunction

  task automatic send_bits(input logic [7:0] b, input logic d,
                           input int n);
    cmd = d;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      sdin = b[7-i];
      repeat (3) @(negedge clk);
      sclk = 1'b1;
      repeat (3) @(negedge clk);
      sclk = 1'b0;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic d);
    send_bits(b, d, 8);
    m_apply(int'(b), d);
  endtask

  task automatic drain(input string tag);
    logic [17:0] a, e;
    logic [8:0]  ba, be;
    repeat (8) @(negedge clk);
    check({tag, " wr count"}, q_wr.size(), e_wr.size());
    while (q_wr.size() > 0 && e_wr.size() > 0) begin
      a = q_wr.pop_front();
      e = e_wr.pop_front();
      check({tag, " wr_addr"}, 32'(a[17:8]), 32'(e[17:8]));
      check({tag, " wr_data"}, 32'(a[7:0]), 32'(e[7:0]));
    end
    q_wr.delete(); e_wr.delete();
    check({tag, " byte count"}, q_bv.size(), e_bv.size());
    while (q_bv.size() > 0 && e_bv.size() > 0) begin
      ba = q_bv.pop_front();
      be = e_bv.pop_front();
      check({tag, " byte"}, 32'(ba), 32'(be));
    end
    q_bv.delete(); e_bv.delete();
    check({tag, " unknown pulses"}, unk_seen, m_unk);
    check({tag, " display_on"}, 32'(display_on), m_disp);
    check({tag, " contrast"}, 32'(contrast), m_con);
    check({tag, " inverse"}, 32'(inverse), m_inv);
    check({tag, " entire_on"}, 32'(entire_on), m_ent);
    check({tag, " addr_mode"}, 32'(addr_mode), m_mode);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " display_on"}, 32'(display_on), 0);
    check({tag, " contrast"}, 32'(contrast), 'h7F);
    check({tag, " inverse"}, 32'(inverse), 0);
    check({tag, " entire_on"}, 32'(entire_on), 0);
    check({tag, " addr_mode"}, 32'(addr_mode), 2);
    check({tag, " wr_en"}, 32'(wr_en), 0);
    check({tag, " wr_addr"}, 32'(wr_addr), 0);
    check({tag, " wr_data"}, 32'(wr_data), 0);
    check({tag, " byte_valid"}, 32'(byte_valid), 0);
    check({tag, " byte_data"}, 32'(byte_data), 0);
    check({tag, " byte_is_data"}, 32'(byte_is_data), 0);
    check({tag, " cmd_unknown"}, 32'(cmd_unknown), 0);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       d;
    logic       e_disp;
    logic [7:0] e_con;
    logic [1:0] e_mode;
    logic       e_inv;
    logic       e_ent;
    int         e_unk;
  } vec_t;

  vec_t tv[17];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int u0;
    int v_exp[9];
    logic [7:0] cl[12];

    tv[0]  = '{8'hAE, 1'b0, 1'b0, 8'h7F, 2'd2, 1'b0, 1'b0, 0};
    tv[1]  = '{8'h20, 1'b0, 1'b0, 8'h7F, 2'd2, 1'b0, 1'b0, 0};
    tv[2]  = '{8'h00, 1'b0, 1'b0, 8'h7F, 2'd0, 1'b0, 1'b0, 0};
    tv[3]  = '{8'h81, 1'b0, 1'b0, 8'h7F, 2'd0, 1'b0, 1'b0, 0};
    tv[4]  = '{8'h7F, 1'b0, 1'b0, 8'h7F, 2'd0, 1'b0, 1'b0, 0};
    tv[5]  = '{8'hA6, 1'b0, 1'b0, 8'h7F, 2'd0, 1'b0, 1'b0, 0};
    tv[6]  = '{8'hA4, 1'b0, 1'b0, 8'h7F, 2'd0, 1'b0, 1'b0, 0};
    tv[7]  = '{8'hAF, 1'b0, 1'b1, 8'h7F, 2'd0, 1'b0, 1'b0, 0};
    tv[8]  = '{8'hA7, 1'b0, 1'b1, 8'h7F, 2'd0, 1'b1, 1'b0, 0};
    tv[9]  = '{8'hA5, 1'b0, 1'b1, 8'h7F, 2'd0, 1'b1, 1'b1, 0};
    tv[10] = '{8'h81, 1'b0, 1'b1, 8'h7F, 2'd0, 1'b1, 1'b1, 0};
    tv[11] = '{8'h3C, 1'b0, 1'b1, 8'h3C, 2'd0, 1'b1, 1'b1, 0};
    tv[12] = '{8'hA4, 1'b0, 1'b1, 8'h3C, 2'd0, 1'b1, 1'b0, 0};
    tv[13] = '{8'h20, 1'b0, 1'b1, 8'h3C, 2'd0, 1'b1, 1'b0, 0};
    tv[14] = '{8'h07, 1'b0, 1'b1, 8'h3C, 2'd0, 1'b1, 1'b0, 0};
    tv[15] = '{8'hE3, 1'b0, 1'b1, 8'h3C, 2'd0, 1'b1, 1'b0, 1};
    tv[16] = '{8'hA6, 1'b0, 1'b1, 8'h3C, 2'd0, 1'b0, 1'b0, 0};

    m_reset();
    m_unk = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("por");
    cs = 1'b0;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      u0 = unk_seen;
      send(tv[i].b, tv[i].d);
      drain($sformatf("vec%0d", i));
      check($sformatf("vec%0d tbl display_on", i),
            32'(display_on), 32'(tv[i].e_disp));
      check($sformatf("vec%0d tbl contrast", i),
            32'(contrast), 32'(tv[i].e_con));
      check($sformatf("vec%0d tbl addr_mode", i),
            32'(addr_mode), 32'(tv[i].e_mode));
      check($sformatf("vec%0d tbl inverse", i),
            32'(inverse), 32'(tv[i].e_inv));
      check($sformatf("vec%0d tbl entire_on", i),
            32'(entire_on), 32'(tv[i].e_ent));
      check($sformatf("vec%0d tbl unknown", i),
            unk_seen - u0, tv[i].e_unk);
    end

    for (int i = 0; i < 1025; i++) send(8'(i), 1'b1);
    repeat (8) @(negedge clk);
    check("horz count", q_wr.size(), 1025);
    if (q_wr.size() == 1025) begin
      check("horz addr127", 32'(q_wr[127][17:8]), 127);
      check("horz addr128", 32'(q_wr[128][17:8]), 128);
      check("horz wrap", 32'(q_wr[1024][17:8]), 0);
    end
    drain("horz");

    send(8'h20, 1'b0); send(8'h01, 1'b0);
    send(8'hB0, 1'b0); send(8'h00, 1'b0); send(8'h10, 1'b0);
    for (int i = 0; i < 9; i++) send(8'(8'hC0 + i), 1'b1);
    repeat (8) @(negedge clk);
    v_exp = '{0, 128, 256, 384, 512, 640, 768, 896, 1};
    check("vert count", q_wr.size(), 9);
    if (q_wr.size() == 9)
      for (int i = 0; i < 9; i++)
        check($sformatf("vert addr%0d", i),
              32'(q_wr[i][17:8]), v_exp[i]);
    drain("vert");

    send(8'h20, 1'b0); send(8'h02, 1'b0);
    send(8'hB3, 1'b0); send(8'h05, 1'b0); send(8'h12, 1'b0);
    send(8'h11, 1'b1); send(8'h22, 1'b1);
    repeat (8) @(negedge clk);
    check("page count", q_wr.size(), 2);
    if (q_wr.size() == 2) begin
      check("page addr0", 32'(q_wr[0][17:8]), 3 * 128 + 37);
      check("page addr1", 32'(q_wr[1][17:8]), 3 * 128 + 38);
    end
    drain("page");

    send_bits(8'hA5, 1'b1, 5);
    cs = 1'b1;
    repeat (6) @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    drain("abort");
    send(8'hA7, 1'b0);
    drain("after abort");

    send(8'h81, 1'b0);
    cs = 1'b1;
    repeat (6) @(negedge clk);
    cs = 1'b0;
    repeat (4) @(negedge clk);
    send(8'h40, 1'b0);
    drain("arg persist");
    check("arg persist contrast", 32'(contrast), 'h40);

    send(8'hAF, 1'b0);
    send(8'h20, 1'b0); send(8'h00, 1'b0);
    drain("pre softreset");
    send_bits(8'h5A, 1'b1, 4);
    res = 1'b0;
    repeat (8) @(negedge clk);
    check_reset_outputs("softreset");
    res = 1'b1;
    repeat (6) @(negedge clk);
    m_reset();
    drain("softreset");
    send(8'h33, 1'b1);
    drain("after softreset");

    cl = '{8'hAE, 8'hAF, 8'hA4, 8'hA5, 8'hA6, 8'hA7,
           8'h81, 8'h20, 8'hB2, 8'hB9, 8'hE3, 8'h1F};
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) < 5) begin
        send(8'($urandom), 1'b1);
      end else if ($urandom_range(0, 3) == 0) begin
        send(8'($urandom), 1'b0);
      end else begin
        send(cl[$urandom_range(0, 11)], 1'b0);
        if (m_st == 2) send(8'($urandom_range(0, 3)), 1'b0);
      end
      if (i % 20 == 19) drain($sformatf("rand%0d", i));
    end
    drain("rand end");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
